// File: rtl/bp_be_fe_queue_rollback.sv
// FE->BE fetch queue with speculative read, commit and replay pointers (issue/commit/roll/clear).
// Latency: enqueue visible on v_o the next cycle; 0 cycles when BP_BE_FE_QUEUE_BYPASS_EN is defined and queue is empty.
// Backpressure: ready_o drops when uncommitted entries fill the queue; a slot frees only on deq_i.
//
// Optional feature macro: BP_BE_FE_QUEUE_BYPASS_EN (same-cycle bypass of data_i to data_o when empty).
// Entries remain resident after issue until committed so a BE miss can replay them.

module bp_be_fe_queue_rollback #(
  parameter int els_p   = 8,
  parameter int width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,

  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,

  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i,

  input  logic               clr_i,
  input  logic               roll_i,
  input  logic               deq_i
);

  localparam int lg_els_lp = $clog2(els_p);
  localparam int ptr_w_lp  = lg_els_lp + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [ptr_w_lp-1:0] cptr_q, cptr_d;

  // Storage is intentionally not reset; pointers alone define valid contents.
  logic [width_p-1:0] mem_q [els_p];

  logic                 full;
  logic                 empty;
  logic                 enq;
  logic [ptr_w_lp-1:0]  cptr_n;
  logic [lg_els_lp-1:0] widx;
  logic [lg_els_lp-1:0] ridx;
  logic [lg_els_lp-1:0] cidx;

  assign widx = wptr_q[lg_els_lp-1:0];
  assign ridx = rptr_q[lg_els_lp-1:0];
  assign cidx = cptr_q[lg_els_lp-1:0];

  // Full is measured against the commit pointer: issued-but-uncommitted entries still occupy space.
  assign full  = (widx == cidx) && (wptr_q[lg_els_lp] != cptr_q[lg_els_lp]);
  assign empty = (rptr_q == wptr_q);

  assign ready_o = ~full;

  // A clear drops any same-cycle write so the flushed packet can never emerge.
  assign enq = v_i & ~full & ~clr_i;

  // Issue side: v_o/data_o from the read pointer, optionally bypassing an arriving packet when empty.
`ifdef BP_BE_FE_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass = empty & v_i & ~full & ~clr_i & ~roll_i;

  always_comb begin
    v_o    = ~empty | bypass;
    data_o = bypass ? data_i : mem_q[ridx];
  end
`else
  always_comb begin
    v_o    = ~empty;
    data_o = mem_q[ridx];
  end
`endif

  // Next-pointer computation: clear beats roll, roll beats normal issue; enqueue survives a roll.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cptr_d = cptr_q;
    cptr_n = cptr_q + {{(ptr_w_lp-1){1'b0}}, deq_i};

    if (clr_i) begin
      // Everything outstanding is discarded by collapsing both read-side pointers onto wptr.
      rptr_d = wptr_q;
      cptr_d = wptr_q;
    end else begin
      wptr_d = wptr_q + {{(ptr_w_lp-1){1'b0}}, enq};
      cptr_d = cptr_n;
      if (roll_i) begin
        // Replay from the oldest uncommitted entry, including a commit happening this cycle.
        rptr_d = cptr_n;
      end else begin
        rptr_d = rptr_q + {{(ptr_w_lp-1){1'b0}}, yumi_i};
      end
    end
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  // Packet storage write; a packet arriving during reset is discarded with everything else.
  always_ff @(posedge clk_i) begin
    if (enq && !reset_i) begin
      mem_q[widx] <= data_i;
    end
  end

`ifndef SYNTHESIS
  logic [ptr_w_lp-1:0] issued_cnt;
  logic [ptr_w_lp-1:0] resident_cnt;

  assign issued_cnt   = rptr_q - cptr_q;
  assign resident_cnt = wptr_q - cptr_q;

  // Protocol and pointer-ordering checks.
  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert ((issued_cnt <= resident_cnt) && (resident_cnt <= ptr_w_lp'(els_p)))
        else $error("pointer order violated: c=%0d r=%0d w=%0d", cptr_q, rptr_q, wptr_q);
      assert (!yumi_i || v_o)
        else $error("yumi_i asserted without v_o");
      assert (!deq_i || (cptr_q != rptr_q))
        else $error("deq_i asserted with no issued entry");
      assert (!(enq && full))
        else $error("write attempted while full");
    end
  end
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_rollback.sv
module tb_bp_be_fe_queue_rollback;

  localparam int ELS = 8;
  localparam int W   = 64;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [W-1:0] data_i;
  logic         v_i;
  logic         ready_o;
  logic [W-1:0] data_o;
  logic         v_o;
  logic         yumi_i;
  logic         clr_i;
  logic         roll_i;
  logic         deq_i;

  int checks = 0;
  int errors = 0;

  bp_be_fe_queue_rollback #(.els_p(ELS), .width_p(W)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .data_i  (data_i),
    .v_i     (v_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .v_o     (v_o),
    .yumi_i  (yumi_i),
    .clr_i   (clr_i),
    .roll_i  (roll_i),
    .deq_i   (deq_i)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pk(input int k);
    return 64'hC0DE_0000_0000_0000 | 64'(k);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v_i    = 1'b0;
    data_i = '0;
    yumi_i = 1'b0;
    clr_i  = 1'b0;
    roll_i = 1'b0;
    deq_i  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ready_o, v_o} !== 2'b10) begin
      errors++;
      $display("FAIL reset_state: ready_o,v_o got %b want 10", {ready_o, v_o});
    end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      v_i = 1'b1; data_i = pk(i);
      step();
      checks++;
      if (ready_o !== 1'b1) begin
        errors++;
        $display("FAIL basic_ready[%0d]: got %b want 1", i, ready_o);
      end
      if (i == 0) begin
        checks++;
        if ({v_o, data_o} !== {1'b1, pk(0)}) begin
          errors++;
          $display("FAIL basic_latency: v/data got %b/%h want 1/%h", v_o, data_o, pk(0));
        end
      end
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({v_o, data_o} !== {1'b1, pk(i)}) begin
        errors++;
        $display("FAIL basic_order[%0d]: v/data got %b/%h want 1/%h", i, v_o, data_o, pk(i));
      end
      yumi_i = 1'b1;
      step();
      yumi_i = 1'b0;
    end
    checks++;
    if (v_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_drained: v_o got %b want 0", v_o);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < ELS; i++) begin
      checks++;
      if (ready_o !== 1'b1) begin
        errors++;
        $display("FAIL full_ready_before[%0d]: got %b want 1", i, ready_o);
      end
      v_i = 1'b1; data_i = pk(10 + i);
      step();
    end
    // Keep offering a packet while full; it must not be stored.
    data_i = pk(99);
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_after8: ready_o got %b want 0", ready_o);
    end
    step();
    idle();
    for (int i = 0; i < ELS; i++) begin
      checks++;
      if ({v_o, data_o} !== {1'b1, pk(10 + i)}) begin
        errors++;
        $display("FAIL full_order[%0d]: v/data got %b/%h want 1/%h", i, v_o, data_o, pk(10 + i));
      end
      yumi_i = 1'b1;
      step();
      yumi_i = 1'b0;
    end
    checks++;
    if ({ready_o, v_o} !== 2'b00) begin
      errors++;
      $display("FAIL full_issued_all: ready_o,v_o got %b want 00", {ready_o, v_o});
    end
    deq_i = 1'b1;
    step();
    deq_i = 1'b0;
    checks++;
    if ({ready_o, v_o} !== 2'b10) begin
      errors++;
      $display("FAIL full_deq_frees: ready_o,v_o got %b want 10", {ready_o, v_o});
    end
    // Refill the freed slot, then deq with v_i while full: write must be dropped.
    v_i = 1'b1; data_i = pk(20);
    step();
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_refill: ready_o got %b want 0", ready_o);
    end
    data_i = pk(21); deq_i = 1'b1;
    step();
    idle();
    checks++;
    if ({ready_o, v_o, data_o} !== {2'b11, pk(20)}) begin
      errors++;
      $display("FAIL full_enq_deq: ready/v/data got %b/%b/%h want 1/1/%h", ready_o, v_o, data_o, pk(20));
    end
  endtask

  task automatic test_roll();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v_i = 1'b1; data_i = pk(30 + i);
      step();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      yumi_i = 1'b1;
      step();
    end
    idle();
    deq_i = 1'b1;
    step();
    idle();
    roll_i = 1'b1;
    step();
    idle();
    for (int i = 1; i < 4; i++) begin
      checks++;
      if ({v_o, data_o} !== {1'b1, pk(30 + i)}) begin
        errors++;
        $display("FAIL roll_replay[%0d]: v/data got %b/%h want 1/%h", i, v_o, data_o, pk(30 + i));
      end
      yumi_i = 1'b1;
      step();
      yumi_i = 1'b0;
    end
    checks++;
    if (v_o !== 1'b0) begin
      errors++;
      $display("FAIL roll_drained: v_o got %b want 0", v_o);
    end
    // Roll with a same-cycle commit of B: replay restarts at C.
    roll_i = 1'b1; deq_i = 1'b1;
    step();
    idle();
    checks++;
    if ({v_o, data_o} !== {1'b1, pk(32)}) begin
      errors++;
      $display("FAIL roll_with_deq: v/data got %b/%h want 1/%h", v_o, data_o, pk(32));
    end
  endtask

  task automatic test_clr();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v_i = 1'b1; data_i = pk(40 + i);
      step();
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      yumi_i = 1'b1;
      step();
    end
    idle();
    clr_i = 1'b1; v_i = 1'b1; data_i = pk(44); yumi_i = 1'b1;
    step();
    idle();
    checks++;
    if ({ready_o, v_o} !== 2'b10) begin
      errors++;
      $display("FAIL clr_state: ready_o,v_o got %b want 10", {ready_o, v_o});
    end
    step();
    checks++;
    if (v_o !== 1'b0) begin
      errors++;
      $display("FAIL clr_no_E: v_o got %b want 0", v_o);
    end
    // Roll after clear must not resurrect flushed entries.
    roll_i = 1'b1;
    step();
    idle();
    checks++;
    if (v_o !== 1'b0) begin
      errors++;
      $display("FAIL clr_roll_empty: v_o got %b want 0", v_o);
    end
    v_i = 1'b1; data_i = pk(45);
    step();
    idle();
    checks++;
    if ({v_o, data_o} !== {1'b1, pk(45)}) begin
      errors++;
      $display("FAIL clr_new_entry: v/data got %b/%h want 1/%h", v_o, data_o, pk(45));
    end
  endtask

  task automatic test_wrap();
    int  wcnt, rcnt, ccnt;
    logic exp_ready, exp_v, do_yumi, do_deq;
    do_reset();
    wcnt = 0; rcnt = 0; ccnt = 0;
    for (int i = 0; i < 40; i++) begin
      exp_ready = ((wcnt - ccnt) != ELS);
      exp_v     = (rcnt != wcnt);
      checks++;
      if ({ready_o, v_o} !== {exp_ready, exp_v}) begin
        errors++;
        $display("FAIL wrap_flags[%0d]: ready_o,v_o got %b%b want %b%b", i, ready_o, v_o, exp_ready, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (data_o !== pk(100 + rcnt)) begin
          errors++;
          $display("FAIL wrap_data[%0d]: got %h want %h", i, data_o, pk(100 + rcnt));
        end
      end
      do_yumi = exp_v && ((i % 3) != 0);
      do_deq  = (rcnt > ccnt) && ((i >= 24) || ((i % 2) == 0));
      v_i = 1'b1; data_i = pk(100 + wcnt);
      yumi_i = do_yumi; deq_i = do_deq;
      step();
      if (exp_ready) wcnt++;
      if (do_yumi) rcnt++;
      if (do_deq) ccnt++;
    end
    idle();
  endtask

`ifdef BP_BE_FE_QUEUE_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    v_i = 1'b1; data_i = pk(200); yumi_i = 1'b1;
    #1;
    checks++;
    if ({v_o, data_o} !== {1'b1, pk(200)}) begin
      errors++;
      $display("FAIL bypass_same_cycle: v/data got %b/%h want 1/%h", v_o, data_o, pk(200));
    end
    step();
    idle();
    #1;
    checks++;
    if (v_o !== 1'b0) begin
      errors++;
      $display("FAIL bypass_consumed: v_o got %b want 0", v_o);
    end
    roll_i = 1'b1;
    step();
    idle();
    checks++;
    if ({v_o, data_o} !== {1'b1, pk(200)}) begin
      errors++;
      $display("FAIL bypass_roll: v/data got %b/%h want 1/%h", v_o, data_o, pk(200));
    end
  endtask
`endif

  initial begin
    idle();
    reset_i = 1'b1;
    test_reset();
    test_basic();
    test_full();
    test_roll();
    test_clr();
    test_wrap();
`ifdef BP_BE_FE_QUEUE_BYPASS_EN
    test_bypass();
`endif
    // Reset mid-operation discards contents.
    v_i = 1'b1; data_i = pk(300);
    step();
    do_reset();
    checks++;
    if ({ready_o, v_o} !== 2'b10) begin
      errors++;
      $display("FAIL midreset: ready_o,v_o got %b want 10", {ready_o, v_o});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
